// File: rtl/v3_peak_detector_if.sv
// ----------------------------------------------------------------------------
// v3_peak_detector_if : event valid/ready bus from the peak detector to readout
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface v3_peak_detector_if #(
  parameter int SIZE_IN = 17,
  parameter int TS_W    = 32,
  parameter int WID_W   = 8
);
  logic                      ev_valid;
  logic                      ev_ready;
  logic signed [SIZE_IN-1:0] ev_amp;
  logic [TS_W-1:0]           ev_time;
  logic [WID_W-1:0]          ev_width;
  logic                      ev_pileup;

  modport master (
    output ev_valid, ev_amp, ev_time, ev_width, ev_pileup,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_amp, ev_time, ev_width, ev_pileup,
    output ev_ready
  );
endinterface

`default_nettype wire

// File: rtl/v3_peak_detector.sv
// ----------------------------------------------------------------------------
// v3_peak_detector : threshold pulse detector with peak/time/width capture
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module v3_peak_detector #(
  parameter int SIZE_IN   = 17,
  parameter int TS_W      = 32,
  parameter int WID_W     = 8,
  parameter int MAX_WIDTH = 64,
  parameter int HOLDOFF   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [SIZE_IN-1:0] input_data,
  input  logic signed [SIZE_IN-1:0] threshold,
  v3_peak_detector_if.master        ev,
  output logic [7:0]                drop_count
);

  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [31:0] MAX_W = 32'(MAX_WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]                state;
  logic [1:0]                state_nx;
  logic [TS_W-1:0]           ts;
  logic signed [SIZE_IN-1:0] max;
  logic [TS_W-1:0]           max_t;
  logic [WID_W-1:0]          wid;
  logic [HC_W-1:0]           hcnt;
  logic                      above;
  logic                      emit;
  logic                      load;
  logic                      pileup;

  assign above  = input_data > threshold;
  assign pileup = 32'(wid) > MAX_W;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (above) state_nx = S_PULSE;
      S_PULSE: if (!above) state_nx = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
      S_HOLD:  if (hcnt == HC_W'(1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // An accept in the same cycle frees the single-entry register for the new event.
  always_comb begin
    emit = 1'b0;
    if (state == S_PULSE && !above) emit = 1'b1;
    load = emit && (!ev.ev_valid || ev.ev_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts    <= '0;
      max   <= '0;
      max_t <= '0;
      wid   <= '0;
      hcnt  <= '0;
    end else begin
      ts <= ts + 1'b1;
      case (state)
        S_IDLE: begin
          if (above) begin
            max   <= input_data;
            max_t <= ts;
            wid   <= WID_W'(1);
          end
        end
        S_PULSE: begin
          if (above) begin
            if (wid != '1) wid <= wid + 1'b1;
            // Strict compare: on a tie the earlier sample keeps the peak.
            if (input_data > max) begin
              max   <= input_data;
              max_t <= ts;
            end
          end else begin
            hcnt <= HC_W'(HOLDOFF);
          end
        end
        S_HOLD:  hcnt <= hcnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev.ev_valid  <= 1'b0;
      ev.ev_amp    <= '0;
      ev.ev_time   <= '0;
      ev.ev_width  <= '0;
      ev.ev_pileup <= 1'b0;
      drop_count   <= '0;
    end else if (load) begin
      ev.ev_valid  <= 1'b1;
      ev.ev_amp    <= max;
      ev.ev_time   <= max_t;
      ev.ev_width  <= wid;
      ev.ev_pileup <= pileup;
    end else begin
      if (emit && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      if (!emit && ev.ev_ready) ev.ev_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_v3_peak_detector.sv
// ----------------------------------------------------------------------------
// tb_v3_peak_detector : vector table plus event scoreboard for v3_peak_detector
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_v3_peak_detector;

  typedef struct packed {
    logic signed [16:0] amp;
    logic [31:0]        t;
    logic [7:0]         w;
    logic               p;
  } ev_t;

  typedef struct {
    logic signed [16:0] din;
    logic signed [16:0] thr;
    logic               rdy;
    logic               push;
    ev_t                ev;
    logic               x_valid;
    logic [7:0]         x_drop;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic signed [16:0] in0, thr0, in1, thr1;
  logic [7:0]         drop0, drop1;

  v3_peak_detector_if #(.SIZE_IN(17), .TS_W(32), .WID_W(8)) b0 ();
  v3_peak_detector_if #(.SIZE_IN(17), .TS_W(32), .WID_W(8)) b1 ();

  v3_peak_detector #(
    .SIZE_IN(17), .TS_W(32), .WID_W(8), .MAX_WIDTH(64), .HOLDOFF(0)
  ) dut0 (
    .clk(clk), .reset(reset), .input_data(in0), .threshold(thr0),
    .ev(b0), .drop_count(drop0)
  );

  v3_peak_detector #(
    .SIZE_IN(17), .TS_W(32), .WID_W(8), .MAX_WIDTH(64), .HOLDOFF(16)
  ) dut1 (
    .clk(clk), .reset(reset), .input_data(in1), .threshold(thr1),
    .ev(b1), .drop_count(drop1)
  );

  ev_t  q0[$];
  ev_t  q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ts_m   = 0;
  vec_t tbl[26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic sb_chk(input int which, input ev_t got);
    ev_t e;
    int  sz;
    sz = (which == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_chk++;
      $display("FAIL ev%0d_unexpected: got amp=%0d time=%0d width=%0d, expected no event",
               which, got.amp, got.t, got.w);
    end else begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      chk($sformatf("ev%0d_fields", which), 64'(got), 64'(e));
    end
  endtask

  // Handshake is judged just before the edge; the bench clock ts_m tracks sample stamps.
  task automatic step();
    ev_t g0, g1;
    logic hs0, hs1;
    @(negedge clk);
    hs0 = b0.ev_valid && b0.ev_ready;
    hs1 = b1.ev_valid && b1.ev_ready;
    g0  = {b0.ev_amp, b0.ev_time, b0.ev_width, b0.ev_pileup};
    g1  = {b1.ev_amp, b1.ev_time, b1.ev_width, b1.ev_pileup};
    if (hs0) sb_chk(0, g0);
    if (hs1) sb_chk(1, g1);
    @(posedge clk);
    #1;
    if (reset) ts_m = 0;
    else       ts_m++;
  endtask

  function automatic vec_t V(input int din, input int thr, input bit rdy, input bit push,
                             input int amp, input int t, input int w, input bit p,
                             input bit xv, input int xd);
    vec_t v;
    v.din     = 17'(din);
    v.thr     = 17'(thr);
    v.rdy     = rdy;
    v.push    = push;
    v.ev.amp  = 17'(amp);
    v.ev.t    = 32'(t);
    v.ev.w    = 8'(w);
    v.ev.p    = p;
    v.x_valid = xv;
    v.x_drop  = 8'(xd);
    return v;
  endfunction

  task automatic pulse0(input int len, input int amp);
    ev_t e;
    e.amp = 17'(amp);
    e.t   = 32'(ts_m);
    e.w   = (len > 255) ? 8'd255 : 8'(len);
    e.p   = (len > 64);
    thr0  = 17'sd100;
    in0   = 17'(amp);
    for (int k = 0; k < len; k++) step();
    in0 = '0;
    q0.push_back(e);
    step();
    chk($sformatf("pulse%0d_valid", len), 64'(b0.ev_valid), 64'(1));
    step();
  endtask

  initial begin
    ev_t e;
    int  t_term;

    // row index equals the timestamp of the sample it drives
    tbl[0]  = V(   0,  100, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[1]  = V(  50,  100, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[2]  = V( 150,  100, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[3]  = V( 300,  100, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[4]  = V( 200,  100, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[5]  = V(  90,  100, 1, 1, 300,  3, 3, 0, 1, 0);
    tbl[6]  = V(   0,  100, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[7]  = V( -50,  -20, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[8]  = V( -10,  -20, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[9]  = V(  40,  -20, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[10] = V(  40,  -20, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[11] = V( -30,  -20, 1, 1,  40,  9, 3, 0, 1, 0);
    tbl[12] = V(-100,  -20, 1, 0,   0,  0, 0, 0, 0, 0);
    tbl[13] = V( 200,  100, 0, 0,   0,  0, 0, 0, 0, 0);
    tbl[14] = V(   0,  100, 0, 1, 200, 13, 1, 0, 1, 0);
    tbl[15] = V( 500,  100, 0, 0,   0,  0, 0, 0, 1, 0);
    tbl[16] = V(   0,  100, 0, 0,   0,  0, 0, 0, 1, 1);
    tbl[17] = V(   0,  100, 1, 0,   0,  0, 0, 0, 0, 1);
    tbl[18] = V( 200,  100, 0, 0,   0,  0, 0, 0, 0, 1);
    tbl[19] = V(   0,  100, 0, 1, 200, 18, 1, 0, 1, 1);
    tbl[20] = V( 300,  100, 0, 0,   0,  0, 0, 0, 1, 1);
    tbl[21] = V(   0,  100, 1, 1, 300, 20, 1, 0, 1, 1);
    tbl[22] = V(   0,  100, 1, 0,   0,  0, 0, 0, 0, 1);
    tbl[23] = V( 150,  100, 1, 0,   0,  0, 0, 0, 0, 1);
    tbl[24] = V( 150,  200, 1, 1, 150, 23, 1, 0, 1, 1);
    tbl[25] = V(   0,  100, 1, 0,   0,  0, 0, 0, 0, 1);

    reset = 1'b1;
    in0 = '0; thr0 = 17'sd100; in1 = '0; thr1 = 17'sd100;
    b0.ev_ready = 1'b1;
    b1.ev_ready = 1'b1;
    step();
    step();
    chk("rst_valid",  64'(b0.ev_valid),  64'(0));
    chk("rst_amp",    64'(b0.ev_amp),    64'(0));
    chk("rst_time",   64'(b0.ev_time),   64'(0));
    chk("rst_width",  64'(b0.ev_width),  64'(0));
    chk("rst_pileup", 64'(b0.ev_pileup), 64'(0));
    chk("rst_drop",   64'(drop0),        64'(0));
    chk("rst_valid1", 64'(b1.ev_valid),  64'(0));
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      in0 = tbl[i].din;
      thr0 = tbl[i].thr;
      b0.ev_ready = tbl[i].rdy;
      if (tbl[i].push) q0.push_back(tbl[i].ev);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(b0.ev_valid), 64'(tbl[i].x_valid));
      chk($sformatf("vec%0d_drop", i),  64'(drop0),       64'(tbl[i].x_drop));
    end

    pulse0(64, 1000);
    pulse0(65, 900);
    pulse0(300, 1000);

    // Hold-off: second pulse arrives mid-hold and must only count from the first free sample.
    in1 = 17'sd500;
    e = {17'sd500, 32'(ts_m), 8'd1, 1'b0};
    step();
    in1 = '0;
    t_term = ts_m;
    q1.push_back(e);
    step();
    chk("hold_first_valid", 64'(b1.ev_valid), 64'(1));
    for (int k = 1; k < 10; k++) step();
    in1 = 17'sd600;
    for (int k = 10; k < 17; k++) step();
    chk("hold_ignored", 64'(b1.ev_valid), 64'(0));
    in1 = 17'sd700;
    step();
    in1 = 17'sd650;
    step();
    in1 = '0;
    q1.push_back({17'sd700, 32'(t_term + 17), 8'd2, 1'b0});
    step();
    chk("hold_second_valid", 64'(b1.ev_valid), 64'(1));
    for (int k = 0; k < 20; k++) step();

    // Reset in the middle of a pulse discards it and restarts the timestamp.
    in0 = 17'sd400;
    thr0 = 17'sd100;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("midrst_valid",  64'(b0.ev_valid),  64'(0));
    chk("midrst_amp",    64'(b0.ev_amp),    64'(0));
    chk("midrst_time",   64'(b0.ev_time),   64'(0));
    chk("midrst_width",  64'(b0.ev_width),  64'(0));
    chk("midrst_pileup", 64'(b0.ev_pileup), 64'(0));
    chk("midrst_drop",   64'(drop0),        64'(0));
    reset = 1'b0;
    in0 = '0;
    step();
    chk("midrst_no_event", 64'(b0.ev_valid), 64'(0));
    in0 = 17'sd250;
    step();
    in0 = '0;
    q0.push_back({17'sd250, 32'd1, 8'd1, 1'b0});
    step();
    chk("postrst_valid", 64'(b0.ev_valid), 64'(1));
    step();
    step();

    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
